// File: rtl/noc_pkg.sv
// ============================================================================
//  noc_pkg : shared NoC flit types and merge-stage state encoding
//  Rev 1.0
// ============================================================================
`default_nettype none

package noc_pkg;

   localparam int FLIT_W = 9;
   localparam int ADDR_W = 4;

   typedef logic [FLIT_W-1:0] flit_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BOTH  = 2'd1,
      W_OUT = 2'd2,
      W_SEL = 2'd3
   } merge_state_e;

   localparam logic SEL_IN0 = 1'b0;
   localparam logic SEL_IN1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_grant2.sv
// ============================================================================
//  rr_grant2 : two-way round-robin grant with burst limit, plus the
//              prio/burst update applied when a grant is accepted.  Rev 1.0
// ============================================================================
`default_nettype none

module rr_grant2 #(
   parameter int MAX_BURST = 4,
   parameter int BW        = 2
) (
   input  logic [1:0]    req_i,
   input  logic          prio_i,
   input  logic          last_src_i,
   input  logic          last_vld_i,
   input  logic [BW-1:0] burst_i,
   input  logic          acc_src_i,
   output logic [1:0]    gnt_o,
   output logic          prio_nxt_o,
   output logic [BW-1:0] burst_nxt_o
);
   import noc_pkg::*;

   localparam logic [BW-1:0] c_BURST_MAX = BW'(MAX_BURST - 1);
   localparam logic [BW-1:0] c_ONE       = BW'(1);

   logic w_pick;
   logic w_other_req;

   always_comb begin
      w_pick = prio_i;
      gnt_o  = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11: begin
            // the owner that has used up its burst yields to the other input
            if (last_vld_i && (prio_i == last_src_i) && (burst_i == c_BURST_MAX))
               w_pick = ~prio_i;
            gnt_o = (w_pick == SEL_IN1) ? 2'b10 : 2'b01;
         end
         default: gnt_o = 2'b00;
      endcase
   end

   always_comb begin
      w_other_req = (acc_src_i == SEL_IN1) ? req_i[0] : req_i[1];
      prio_nxt_o  = w_other_req ? ~acc_src_i : acc_src_i;
      burst_nxt_o = '0;
      if (last_vld_i && (acc_src_i == last_src_i))
         burst_nxt_o = (burst_i == c_BURST_MAX) ? burst_i : burst_i + c_ONE;
   end

endmodule

`default_nettype wire

// File: rtl/merge2_rr_arbiter.sv
// ============================================================================
//  merge2_rr_arbiter : two-input round-robin flit merge with paired select
//                      token; all outputs registered.  Rev 1.0
// ============================================================================
`default_nettype none

module merge2_rr_arbiter #(
   parameter int W         = 9,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in0_valid,
   output logic         in0_ready,
   input  logic [W-1:0] in0_data,
   input  logic         in1_valid,
   output logic         in1_ready,
   input  logic [W-1:0] in1_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         sel_valid,
   input  logic         sel_ready,
   output logic         sel_data
);
   import noc_pkg::*;

   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   merge_state_e  state_q, state_d;
   logic [1:0]    grant_q, grant_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic          sel_data_q, sel_data_d;
   logic          out_valid_q, out_valid_d;
   logic          sel_valid_q, sel_valid_d;
   logic          prio_q, prio_d;
   logic          last_src_q, last_src_d;
   logic          last_vld_q, last_vld_d;
   logic [BW-1:0] burst_q, burst_d;

   logic [1:0]    w_gnt;
   logic          w_prio_nxt;
   logic [BW-1:0] w_burst_nxt;
   logic          w_acc0, w_acc1, w_acc;

   assign w_acc0 = (state_q == IDLE) && grant_q[0] && in0_valid;
   assign w_acc1 = (state_q == IDLE) && grant_q[1] && in1_valid;
   assign w_acc  = w_acc0 | w_acc1;

   rr_grant2 #(
      .MAX_BURST (MAX_BURST),
      .BW        (BW)
   ) u_grant (
      .req_i       ({in1_valid, in0_valid}),
      .prio_i      (prio_q),
      .last_src_i  (last_src_q),
      .last_vld_i  (last_vld_q),
      .burst_i     (burst_q),
      .acc_src_i   (w_acc1),
      .gnt_o       (w_gnt),
      .prio_nxt_o  (w_prio_nxt),
      .burst_nxt_o (w_burst_nxt)
   );

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      sel_data_d  = sel_data_q;
      out_valid_d = out_valid_q;
      sel_valid_d = sel_valid_q;
      prio_d      = prio_q;
      last_src_d  = last_src_q;
      last_vld_d  = last_vld_q;
      burst_d     = burst_q;
      case (state_q)
         IDLE: begin
            if (w_acc) begin
               state_d     = BOTH;
               out_data_d  = w_acc1 ? in1_data : in0_data;
               sel_data_d  = w_acc1 ? SEL_IN1 : SEL_IN0;
               out_valid_d = 1'b1;
               sel_valid_d = 1'b1;
               prio_d      = w_prio_nxt;
               burst_d     = w_burst_nxt;
               last_src_d  = w_acc1;
               last_vld_d  = 1'b1;
            end
         end
         BOTH: begin
            if (out_ready && sel_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               sel_valid_d = 1'b0;
            end else if (sel_ready) begin
               state_d     = W_OUT;
               sel_valid_d = 1'b0;
            end else if (out_ready) begin
               state_d     = W_SEL;
               out_valid_d = 1'b0;
            end
         end
         W_OUT: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         W_SEL: begin
            if (sel_ready) begin
               state_d     = IDLE;
               sel_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      // grant is registered on the cycle that enters (or stays in) IDLE, so ready
      // is high on the first IDLE cycle and a flit can move every second cycle
      grant_d = (state_d == IDLE) ? w_gnt : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= 2'b00;
         out_data_q  <= '0;
         sel_data_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sel_valid_q <= 1'b0;
         prio_q      <= SEL_IN0;
         last_src_q  <= SEL_IN0;
         last_vld_q  <= 1'b0;
         burst_q     <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         out_data_q  <= out_data_d;
         sel_data_q  <= sel_data_d;
         out_valid_q <= out_valid_d;
         sel_valid_q <= sel_valid_d;
         prio_q      <= prio_d;
         last_src_q  <= last_src_d;
         last_vld_q  <= last_vld_d;
         burst_q     <= burst_d;
      end
   end

   assign in0_ready = grant_q[0];
   assign in1_ready = grant_q[1];
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign sel_valid = sel_valid_q;
   assign sel_data  = sel_data_q;

endmodule

`default_nettype wire

// File: tb/tb_merge2_rr_arbiter.sv
// ============================================================================
//  tb_merge2_rr_arbiter : directed stimulus with queue scoreboard for the
//                         two-input round-robin merge.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_merge2_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in0_valid, in1_valid;
   logic [8:0] in0_data, in1_data;
   logic       in0_ready, in1_ready;
   logic       out_valid, out_ready;
   logic [8:0] out_data;
   logic       sel_valid, sel_ready, sel_data;

   int n_cmp = 0;
   int n_bad = 0;
   int n_out = 0;
   bit rdy0_seen;
   bit hs0, hs1;

   logic [8:0] src0_q[$], src1_q[$];
   logic [8:0] exp_flit[$];
   logic       exp_sel[$];

   always #5 clk = ~clk;

   merge2_rr_arbiter #(.W(9), .MAX_BURST(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_data  (in0_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_data  (in1_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sel_valid (sel_valid),
      .sel_ready (sel_ready),
      .sel_data  (sel_data)
   );

   // source drivers: hold valid/data until the handshake is seen
   always @(negedge clk) begin
      hs0 = in0_valid && (in0_ready === 1'b1) && rst_n;
      hs1 = in1_valid && (in1_ready === 1'b1) && rst_n;
   end

   initial forever begin
      @(posedge clk); #1;
      if (hs0 && src0_q.size() > 0) src0_q.delete(0);
      if (hs1 && src1_q.size() > 0) src1_q.delete(0);
      in0_valid = (src0_q.size() > 0);
      in0_data  = in0_valid ? src0_q[0] : 9'h000;
      in1_valid = (src1_q.size() > 0);
      in1_data  = in1_valid ? src1_q[0] : 9'h000;
   end

   // monitor: pop expected values whenever an output handshake completes
   always @(negedge clk) begin
      if (rst_n) begin
         if (in0_ready) rdy0_seen = 1'b1;
         n_cmp++;
         if (in0_ready && in1_ready) begin
            n_bad++;
            $display("FAIL ready_onehot: got in0_ready=1 in1_ready=1, required at most one");
         end
         if (out_valid && out_ready) begin
            n_out++;
            n_cmp++;
            if (exp_flit.size() == 0) begin
               n_bad++;
               $display("FAIL out_unexpected: got flit %h, required none", out_data);
            end else if (out_data !== exp_flit[0]) begin
               n_bad++;
               $display("FAIL out_data: got %h, required %h", out_data, exp_flit[0]);
            end
            if (exp_flit.size() > 0) exp_flit.delete(0);
         end
         if (sel_valid && sel_ready) begin
            n_cmp++;
            if (exp_sel.size() == 0) begin
               n_bad++;
               $display("FAIL sel_unexpected: got token %0d, required none", sel_data);
            end else if (sel_data !== exp_sel[0]) begin
               n_bad++;
               $display("FAIL sel_data: got %0d, required %0d", sel_data, exp_sel[0]);
            end
            if (exp_sel.size() > 0) exp_sel.delete(0);
         end
      end
   end

   task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic expect_pair(input logic [8:0] f, input logic s);
      exp_flit.push_back(f);
      exp_sel.push_back(s);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((exp_flit.size() > 0 || exp_sel.size() > 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (exp_flit.size() > 0 || exp_sel.size() > 0) begin
         n_bad++;
         $display("FAIL %s drain: got %0d flits %0d tokens outstanding, required 0",
                  nm, exp_flit.size(), exp_sel.size());
         exp_flit.delete();
         exp_sel.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_out(input bit want_sel);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(want_sel ? sel_valid : out_valid) && n < 50);
   endtask

   initial begin
      rst_n     = 1'b0;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      in0_data  = 9'h000;
      in1_data  = 9'h000;
      out_ready = 1'b1;
      sel_ready = 1'b1;

      // reset with both inputs requesting; In0 wins the first grant
      src0_q.push_back(9'h011);
      src1_q.push_back(9'h1E2);
      expect_pair(9'h011, 1'b0);
      expect_pair(9'h1E2, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst in0_ready", {8'h00, in0_ready}, 9'h000);
      chk("rst in1_ready", {8'h00, in1_ready}, 9'h000);
      chk("rst out_valid", {8'h00, out_valid}, 9'h000);
      chk("rst sel_valid", {8'h00, sel_valid}, 9'h000);
      chk("rst out_data",  out_data,           9'h000);
      chk("rst sel_data",  {8'h00, sel_data},  9'h000);
      @(posedge clk); #1 rst_n = 1'b1;
      drain("t1");

      // single source on In1
      do_reset();
      rdy0_seen = 1'b0;
      src1_q.push_back(9'h1A5);
      src1_q.push_back(9'h0F3);
      expect_pair(9'h1A5, 1'b1);
      expect_pair(9'h0F3, 1'b1);
      drain("t2");
      chk("t2 in0_ready never", {8'h00, rdy0_seen}, 9'h000);

      // continuous contention alternates
      do_reset();
      for (int i = 0; i < 4; i++) begin
         src0_q.push_back(9'h010 + 9'(i));
         src1_q.push_back(9'h120 + 9'(i));
         expect_pair(9'h010 + 9'(i), 1'b0);
         expect_pair(9'h120 + 9'(i), 1'b1);
      end
      drain("t3");

      // In0 streams alone, then yields once its burst is used up
      do_reset();
      for (int i = 0; i < 6; i++) begin
         src0_q.push_back(9'h0A0 + 9'(i));
         expect_pair(9'h0A0 + 9'(i), 1'b0);
      end
      drain("t4a");
      src0_q.push_back(9'h0B0);
      src0_q.push_back(9'h0B1);
      src1_q.push_back(9'h1B0);
      src1_q.push_back(9'h1B1);
      expect_pair(9'h1B0, 1'b1);
      expect_pair(9'h0B0, 1'b0);
      expect_pair(9'h1B1, 1'b1);
      expect_pair(9'h0B1, 1'b0);
      drain("t4b");

      // token completes first, flit held (W_OUT)
      do_reset();
      out_ready = 1'b0;
      sel_ready = 1'b1;
      src0_q.push_back(9'h155);
      src0_q.push_back(9'h156);
      expect_pair(9'h155, 1'b0);
      expect_pair(9'h156, 1'b0);
      wait_out(1'b0);
      chk("t5a reach BOTH", {8'h00, out_valid}, 9'h001);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5a out_valid", {8'h00, out_valid}, 9'h001);
         chk("t5a sel_valid", {8'h00, sel_valid}, 9'h000);
         chk("t5a out_data",  out_data,           9'h155);
         chk("t5a in0_ready", {8'h00, in0_ready}, 9'h000);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      drain("t5a");

      // flit completes first, token held (W_SEL)
      do_reset();
      out_ready = 1'b1;
      sel_ready = 1'b0;
      src1_q.push_back(9'h157);
      src1_q.push_back(9'h158);
      expect_pair(9'h157, 1'b1);
      expect_pair(9'h158, 1'b1);
      wait_out(1'b1);
      chk("t5b reach BOTH", {8'h00, sel_valid}, 9'h001);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5b sel_valid", {8'h00, sel_valid}, 9'h001);
         chk("t5b out_valid", {8'h00, out_valid}, 9'h000);
         chk("t5b sel_data",  {8'h00, sel_data},  9'h001);
         chk("t5b in1_ready", {8'h00, in1_ready}, 9'h000);
      end
      @(posedge clk); #1 sel_ready = 1'b1;
      drain("t5b");

      // reset while a flit and token are pending drops them
      do_reset();
      out_ready = 1'b0;
      sel_ready = 1'b0;
      src0_q.push_back(9'h0CC);
      wait_out(1'b0);
      chk("t6 reach BOTH", {8'h00, out_valid & sel_valid}, 9'h001);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1;
      chk("t6 out_valid", {8'h00, out_valid}, 9'h000);
      chk("t6 sel_valid", {8'h00, sel_valid}, 9'h000);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      sel_ready = 1'b1;
      begin
         int n_before;
         n_before = n_out;
         repeat (10) @(negedge clk);
         chk("t6 no emit", 9'(n_out - n_before), 9'h000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
